sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in, parallel-out deserializer with a valid/ready word output. It receives the LSB-first bit stream produced by the team's parallel-to-serial shifters and reassembles each `LEN`-bit frame into a parallel word. A one-word holding register decouples the output so that bit reception continues while the consumer is stalled. It sits at the receive end of the team's serial links, feeding the downstream parallel datapath.

## Interface
- `LEN`, default 8, data word width in bits; legal range is `LEN >= 2`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sample`  in  1  `serial_in` carries a valid bit this cycle.
- `serial_in`  in  1  serial data, LSB of the word first.
- `clear`  in  1  synchronous frame resync: drops any partial frame and clears `overrun`.
- `data_out`  out  `LEN`  assembled word; held stable while `data_valid` is high.
- `data_valid`  out  1  holding register contains a word.
- `data_ready`  in  1  consumer accepts the word.
- `overrun`  out  1  sticky flag: a completed frame was dropped.
- `parity_err`  out  1  parity result of the held word (see Configuration).

## Operation
- Reset values: `data_out=0`, `data_valid=0`, `overrun=0`, `parity_err=0`. The shift register and bit counter are also reset to 0.
- Shift on `sample=1`: `shift_reg <= {serial_in, shift_reg[LEN-1:1]}` and the bit counter increments. The first received bit ends up in bit 0.
- Frame complete when `sample=1` and the counter equals `FRAME_BITS-1`:
  - The counter wraps to 0.
  - The candidate word is `{serial_in, shift_reg[LEN-1:1]}`.
- Holding register FSM, `EMPTY`/`FULL`:
  - `EMPTY` + frame complete: load the word, go to `FULL`.
  - `FULL` + `data_ready`, no frame complete: go to `EMPTY`.
  - `FULL` + `data_ready` + frame complete in the same cycle: load the new word and stay in `FULL`. This is not an overrun.
  - `FULL` + `!data_ready` + frame complete: drop the new word, keep the old word, set `overrun`.
- `data_valid` equals (state == `FULL`).
- `clear` takes priority over `sample` in the same cycle:
  - Counter and shift register go to 0.
  - `overrun` goes to 0.
  - The holding register and `data_valid` are unaffected.
- `sample=0`: the counter and shift register hold, so gaps between bits are allowed.
- `overrun` stays set until `clear` or `rst`.

## Timing
- Latency: `data_valid` rises on the clock edge that samples the final bit of a frame. The word is therefore visible in the cycle after that bit was presented.
- A transfer occurs on a rising edge where `data_valid && data_ready`.
- `data_ready` may be held high permanently; the block never requires it to toggle.
- Throughput: one word per `FRAME_BITS` sampled cycles. At `sample=1` continuously, the consumer must accept within `FRAME_BITS` cycles to avoid `overrun`.
- `rst` asserted mid-frame clears everything immediately. The partial frame is lost and the next sampled bit is treated as bit 0.

## Configuration
- Macro: `SIPO_PARITY_EN`.
- Defined:
  - `FRAME_BITS = LEN+1`.
  - The extra final bit is an even-parity bit over the data bits and is not stored in `data_out`.
  - `parity_err` is loaded together with `data_out` and is 1 when the XOR of the data bits and the parity bit is 1.
  - `parity_err` is valid only while `data_valid` is high.
- Undefined:
  - `FRAME_BITS = LEN`.
  - `parity_err` is tied to 0 and no parity logic is built.

## Structure
- Shared package `sipo_pkg`:
  - Holding FSM state encoding (`ST_EMPTY=1'b0`, `ST_FULL=1'b1`).
  - Counter-width constant/function `CNT_W = $clog2(FRAME_BITS)`.
- Sub-module `bit_counter`:
  - Parameterized modulo-N up-counter with `inc` and synchronous `clr`.
  - Outputs `count` and `last` (`count == N-1`).
- Top level holds the shift register, the holding register/FSM, `overrun` and the optional parity.

## Test plan
- `LEN=8`, `data_ready=1`, send `0xA5` LSB-first with `sample=1` for 8 cycles: `data_out=0xA5` and `data_valid=1` in the cycle after bit 7; it drops 1 cycle later.
- Back-to-back `0x12`, `0x34` with `sample` continuous and `data_ready=1`: two words delivered 8 cycles apart, `overrun=0`.
- `data_ready=0`, send `0x11` then `0x22`: `data_out` stays `0x11` and `overrun=1` after the 16th bit. Asserting `data_ready` then delivers `0x11` only.
- Send 3 bits, pulse `clear`, then send `0x3C` with random `sample` gaps: `data_out=0x3C`, `overrun=0`.
- Assert `rst` after 5 bits of a frame, then send `0xF0`: all outputs 0 during reset, then `data_out=0xF0`.
- With `SIPO_PARITY_EN`, send `0x07` + parity 1 and then `0x07` + parity 0: `parity_err=0` for the first word, 1 for the second.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo_deser serial receiver.
// Frame length depends on SIPO_PARITY_EN (adds one trailing even-parity bit).
package sipo_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

  // Serial bits per frame for a given data width.
  function automatic int unsigned frame_bits(input int unsigned len);
`ifdef SIPO_PARITY_EN
    return len + 1;
`else
    return len;
`endif
  endfunction

  // Bit-counter width for a frame of the given length.
  function automatic int unsigned cnt_w(input int unsigned frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo-N up-counter with increment and synchronous clear; last is
// registered and tracks count == N-1.
module bit_counter
  import sipo_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] MAX_CNT = W'(N - 1);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count == MAX_CNT) ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      last  <= 1'b0;
    end else begin
      count <= count_d;
      last  <= (count_d == MAX_CNT);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer with a one-word valid/ready
// holding register and sticky overrun. Optional parity: SIPO_PARITY_EN.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned LEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample,
  input  logic           serial_in,
  input  logic           clear,
  output logic [LEN-1:0] data_out,
  output logic           data_valid,
  input  logic           data_ready,
  output logic           overrun,
  output logic           parity_err
);

  localparam int unsigned FRAME_BITS = frame_bits(LEN);
  localparam int unsigned CNT_W      = cnt_w(FRAME_BITS);

  hold_state_e    state_q, state_d;
  logic [LEN-1:0] shift_reg;
  logic [LEN-1:0] word_c;
  logic [CNT_W-1:0] cnt;
  logic           cnt_last;
  logic           frame_done_c;
  logic           load_c;
  logic           drop_c;

  bit_counter #(.N(FRAME_BITS)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (sample),
    .clr   (clear),
    .count (cnt),
    .last  (cnt_last)
  );

  // clear outranks sample, so a resync cycle can never complete a frame
  assign frame_done_c = sample && !clear && cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (clear) begin
      shift_reg <= '0;
    end else if (sample) begin
      shift_reg <= {serial_in, shift_reg[LEN-1:1]};
    end
  end

`ifdef SIPO_PARITY_EN
  // Final bit is parity, so the data bits are already fully shifted in.
  assign word_c = shift_reg;
`else
  assign word_c = {serial_in, shift_reg[LEN-1:1]};
`endif

  // Holding-register next state; a same-cycle accept frees the slot for a new word
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (frame_done_c) begin
          load_c  = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (data_ready) begin
          if (frame_done_c) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (frame_done_c) begin
          drop_c = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign data_valid = (state_q == ST_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (load_c) begin
      data_out <= word_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (load_c) begin
      parity_err <= (^shift_reg) ^ serial_in;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Registered last flag must stay aligned with the count it decodes
  ast_last_aligned: assert property (@(posedge clk) disable iff (rst)
    cnt_last == (cnt == CNT_W'(FRAME_BITS - 1)));

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser against a bit-queue reference model.
// Honours SIPO_PARITY_EN (adds the parity-bit scenario).
module tb_sipo_deser;

  localparam int unsigned LEN = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME_BITS = LEN + 1;
`else
  localparam int unsigned FRAME_BITS = LEN;
`endif

  logic           clk;
  logic           rst;
  logic           sample;
  logic           serial_in;
  logic           clear;
  logic [LEN-1:0] data_out;
  logic           data_valid;
  logic           data_ready;
  logic           overrun;
  logic           parity_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic           mq[$];
  logic           exp_valid;
  logic           exp_ovr;
  logic [LEN-1:0] exp_data;
  logic           exp_perr;

  sipo_deser #(.LEN(LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample     (sample),
    .serial_in  (serial_in),
    .clear      (clear),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_data  = '0;
    exp_perr  = 1'b0;
  endtask

  // One clock of behaviour: collect bits, emit a word after FRAME_BITS, then
  // decide whether the one-word buffer accepts it.
  task automatic model_step(input logic s, input logic b, input logic c, input logic r);
    logic           done;
    logic [LEN-1:0] w;
    logic           perr;
    int             ones;
    done = 1'b0;
    w    = '0;
    perr = 1'b0;
    ones = 0;
    if (c) begin
      mq.delete();
      exp_ovr = 1'b0;
    end else if (s) begin
      mq.push_back(b);
      if (mq.size() == FRAME_BITS) begin
        for (int i = 0; i < LEN; i++) begin
          w[i] = mq[i];
          ones += int'(mq[i]);
        end
`ifdef SIPO_PARITY_EN
        ones += int'(mq[LEN]);
        perr = ((ones % 2) != 0);
`endif
        done = 1'b1;
        mq.delete();
      end
    end
    if (done) begin
      if (!exp_valid || r) begin
        exp_data  = w;
        exp_perr  = perr;
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
  endtask

  // Drive at the falling edge, update model at the rising edge, return at the next falling edge.
  task automatic tick(input logic s, input logic b, input logic c, input logic r);
    sample     = s;
    serial_in  = b;
    clear      = c;
    data_ready = r;
    @(posedge clk);
    model_step(s, b, c, r);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [LEN-1:0] word, input logic pbit,
                           input logic r, input int unsigned max_gap);
    for (int i = 0; i < LEN; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick(1'b0, 1'($urandom), 1'b0, r);
      tick(1'b1, word[i], 1'b0, r);
    end
`ifdef SIPO_PARITY_EN
    repeat ($urandom_range(max_gap, 0)) tick(1'b0, 1'($urandom), 1'b0, r);
    tick(1'b1, pbit, 1'b0, r);
`else
    if (pbit) begin end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; sample = 1'b0; serial_in = 1'b0; clear = 1'b0; data_ready = 1'b0;
    model_reset();
    #2;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b exp=0", parity_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    send_word(8'hA5, ^8'hA5, 1'b1, 0);
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", data_valid); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", data_out); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", data_valid); end
  endtask

  task automatic test_back_to_back();
    logic [LEN-1:0] words [2];
    int             seen [2];
    int             n;
    words[0] = 8'h12;
    words[1] = 8'h34;
    n = 0;
    seen[0] = -1;
    seen[1] = -1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME_BITS; i++) begin
        logic bv;
        logic [LEN-1:0] wv;
        wv = words[f];
        bv = (i < LEN) ? wv[i] : ^wv;
        tick(1'b1, bv, 1'b0, 1'b1);
        total++; if (data_valid !== exp_valid) begin bad++; $display("FAIL b2b_valid got=%b exp=%b", data_valid, exp_valid); end
        if (data_valid === 1'b1 && n < 2) begin
          total++; if (data_out !== words[n]) begin bad++; $display("FAIL b2b_data got=%h exp=%h", data_out, words[n]); end
          seen[n] = f * FRAME_BITS + i;
          n++;
        end
      end
    end
    total++; if (seen[1] - seen[0] !== FRAME_BITS) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", seen[1] - seen[0], FRAME_BITS); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    send_word(8'h11, ^8'h11, 1'b0, 0);
    send_word(8'h22, ^8'h22, 1'b0, 0);
    total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", data_out); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", data_valid); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ovr_single_delivery got=%b exp=0", data_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(8'h3C, ^8'h3C, 1'b1, 3);
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL clear_valid got=%b exp=1", data_valid); end
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL clear_data got=%h exp=3c", data_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clear_overrun got=%b exp=0", overrun); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", data_valid); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rstmid_parity got=%b exp=0", parity_err); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_word(8'hF0, ^8'hF0, 1'b1, 0);
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL rstmid_after_valid got=%b exp=1", data_valid); end
    total++; if (data_out !== 8'hF0) begin bad++; $display("FAIL rstmid_after_data got=%h exp=f0", data_out); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    send_word(8'h07, 1'b1, 1'b1, 0);
    total++; if (data_out !== 8'h07) begin bad++; $display("FAIL par_good_data got=%h exp=07", data_out); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_good got=%b exp=0", parity_err); end
    send_word(8'h07, 1'b0, 1'b1, 0);
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_bad got=%b exp=1", parity_err); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(3, 0) != 0), 1'($urandom),
           ($urandom_range(40, 0) == 0), ($urandom_range(2, 0) != 0));
      total++; if (data_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, data_valid, exp_valid); end
      total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL rnd_overrun cyc=%0d got=%b exp=%b", n, overrun, exp_ovr); end
      if (exp_valid) begin
        total++; if (data_out !== exp_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, data_out, exp_data); end
        total++; if (parity_err !== exp_perr) begin bad++; $display("FAIL rnd_parity cyc=%0d got=%b exp=%b", n, parity_err, exp_perr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_clear();
    test_rst_mid();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
